controller: RTL

CONTROLLER -- requirements
Module: controller

---
 rtl/risc_pkg.sv | 46 ++++
 rtl/controller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_pkg
// Description : Shared definitions for the small RISC datapath: opcode
//               encodings, controller state/phase encodings and an ALU-op
//               classifier used by the controller, ALU and decoder logic.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

   typedef enum logic [2:0] {
      OP_HLT = 3'd0,
      OP_SKZ = 3'd1,
      OP_ADD = 3'd2,
      OP_AND = 3'd3,
      OP_XOR = 3'd4,
      OP_LDA = 3'd5,
      OP_STO = 3'd6,
      OP_JMP = 3'd7
   } opcode_e;

   // Normal states use their phase index as encoding so phase is just the
   // low three bits; HALTED sits outside the 0..7 range.
   typedef enum logic [3:0] {
      ST_INST_ADDR  = 4'd0,
      ST_INST_FETCH = 4'd1,
      ST_INST_LOAD  = 4'd2,
      ST_IDLE       = 4'd3,
      ST_OP_ADDR    = 4'd4,
      ST_OP_FETCH   = 4'd5,
      ST_ALU_OP     = 4'd6,
      ST_STORE      = 4'd7,
      ST_HALTED     = 4'd8
   } state_e;

   // HALTED reports the phase in which the halt was taken.
   localparam logic [2:0] c_HALTED_PHASE = 3'd4;

   // Opcodes whose result comes from the ALU and so need an operand read.
   function automatic logic is_aluop(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
   endfunction

endpackage : risc_pkg
`default_nettype wire

// File: rtl/controller.sv
`default_nettype none
// ============================================================================
// Module      : controller
// Description : Eight-phase sequencer for the small RISC CPU. A state
//               register plus a combinational decode of state and opcode
//               produces the datapath control strobes.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous active-high reset
//               opcode  - IR opcode field
//               zero    - accumulator-zero flag
//               sel     - address mux select (1 = PC, 0 = IR operand)
//               rd      - memory read enable
//               ld_ir   - instruction register load
//               inc_pc  - program counter increment
//               ld_pc   - program counter load
//               ld_ac   - accumulator load
//               wr      - memory write strobe
//               data_e  - accumulator drives data bus
//               halt    - CPU halted indication
//               phase   - current phase index
// Parameters  : HALT_STICKY - 1: HLT parks in HALTED until reset,
//                             0: HLT pulses halt for one cycle only
// Revision    : 1.0 - initial release
// ============================================================================
module controller
   import risc_pkg::*;
#(
   parameter bit HALT_STICKY = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       wr,
   output logic       data_e,
   output logic       halt,
   output logic [2:0] phase
);

   state_e state_q;
   state_e state_d;
   logic   w_aluop;
   logic   w_is_hlt;
   logic   w_is_skz;
   logic   w_is_sto;
   logic   w_is_jmp;

   assign w_aluop  = is_aluop(opcode);
   assign w_is_hlt = (opcode == OP_HLT);
   assign w_is_skz = (opcode == OP_SKZ);
   assign w_is_sto = (opcode == OP_STO);
   assign w_is_jmp = (opcode == OP_JMP);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_INST_ADDR;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel     = 1'b0;
      rd      = 1'b0;
      ld_ir   = 1'b0;
      inc_pc  = 1'b0;
      ld_pc   = 1'b0;
      ld_ac   = 1'b0;
      wr      = 1'b0;
      data_e  = 1'b0;
      halt    = 1'b0;
      phase   = state_q[2:0];

      unique case (state_q)
         ST_INST_ADDR: begin
            sel     = 1'b1;
            state_d = ST_INST_FETCH;
         end
         ST_INST_FETCH: begin
            sel     = 1'b1;
            rd      = 1'b1;
            state_d = ST_INST_LOAD;
         end
         ST_INST_LOAD: begin
            sel     = 1'b1;
            rd      = 1'b1;
            ld_ir   = 1'b1;
            state_d = ST_IDLE;
         end
         ST_IDLE: begin
            sel     = 1'b1;
            rd      = 1'b1;
            ld_ir   = 1'b1;
            state_d = ST_OP_ADDR;
         end
         ST_OP_ADDR: begin
            inc_pc  = 1'b1;
            halt    = w_is_hlt;
            state_d = (HALT_STICKY && w_is_hlt) ? ST_HALTED : ST_OP_FETCH;
         end
         ST_OP_FETCH: begin
            rd      = w_aluop;
            state_d = ST_ALU_OP;
         end
         ST_ALU_OP: begin
            rd      = w_aluop;
            // Skip-if-zero: second PC increment jumps over the next word.
            inc_pc  = w_is_skz && zero;
            ld_pc   = w_is_jmp;
            data_e  = w_is_sto;
            state_d = ST_STORE;
         end
         ST_STORE: begin
            rd      = w_aluop;
            ld_ac   = w_aluop;
            ld_pc   = w_is_jmp;
            inc_pc  = w_is_jmp;
            wr      = w_is_sto;
            data_e  = w_is_sto;
            state_d = ST_INST_ADDR;
         end
         ST_HALTED: begin
            halt    = 1'b1;
            phase   = c_HALTED_PHASE;
         end
         default: begin
            state_d = ST_INST_ADDR;
         end
      endcase
   end

endmodule : controller
`default_nettype wire
